// File: rtl/input_feeder.sv
// input_feeder: streams a buffer as optional zero skew beats then matrixSize real beats over valid/ready
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   start                begin one stream (sampled only when idle)
//   busy, done           stream in progress; one-cycle pulse after the last beat is accepted
//   readLocation         index into the buffer's combinational read port
//   readElement          buffer data for readLocation, same cycle
//   outValid, outReady   output handshake
//   outData, outLast     registered beat payload; high on the final real beat
module input_feeder #(
    parameter int matrixSize = 4,
    parameter int dataSize = 16,
    parameter int skewCycles = 0,
    localparam int AW = matrixSize > 1 ? $clog2(matrixSize) : 1,
    localparam int SW = skewCycles > 0 ? $clog2(skewCycles + 1) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic [AW-1:0]       readLocation,
    input  logic [dataSize-1:0] readElement,
    output logic                outValid,
    input  logic                outReady,
    output logic [dataSize-1:0] outData,
    output logic                outLast
);
    typedef enum logic [1:0] {IDLE, SKEW, STREAM} state_t;
    localparam logic [AW-1:0] LAST = AW'(matrixSize - 1);
    localparam logic [SW-1:0] SKN = SW'(skewCycles);
    state_t state, state_n;
    logic [AW-1:0] idx, idx_n;
    logic [SW-1:0] sk, sk_n;
    logic [dataSize-1:0] data_n;
    logic valid_n, last_n, accept, finish, load_zero, load_real;
    assign accept = outValid & outReady;
    assign readLocation = idx;
    assign busy = state != IDLE;
    // idx is the index of the next real element to load; it parks on the
    // final index so readLocation never leaves the buffer range.
    // sk counts zero beats loaded; it is 0 whenever the block is idle.
    always_comb begin
        finish = state == STREAM && accept && outLast;
        load_zero = skewCycles > 0 && ((state == IDLE && start) || (state == SKEW && accept && sk != SKN));
        load_real = (state == IDLE && start && skewCycles == 0) || (state == SKEW && accept && sk == SKN) ||
                    (state == STREAM && accept && !outLast);
        state_n = finish ? IDLE : load_real ? STREAM : load_zero ? SKEW : state;
        idx_n = finish ? '0 : (load_real && idx != LAST) ? idx + AW'(1) : idx;
        sk_n = finish ? '0 : load_zero ? sk + SW'(1) : sk;
        valid_n = finish ? 1'b0 : (load_zero || load_real) ? 1'b1 : outValid;
        data_n = load_real ? readElement : load_zero ? '0 : outData;
        last_n = finish ? 1'b0 : load_real ? idx == LAST : load_zero ? 1'b0 : outLast;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            idx <= '0;
            sk <= '0;
            outValid <= 1'b0;
            outData <= '0;
            outLast <= 1'b0;
            done <= 1'b0;
        end else begin
            state <= state_n;
            idx <= idx_n;
            sk <= sk_n;
            outValid <= valid_n;
            outData <= data_n;
            outLast <= last_n;
            done <= finish;
        end
    end
endmodule

// File: tb/tb_input_feeder.sv
module tb_input_feeder;
    logic clk = 0, rst = 0, start0 = 0, start1 = 0, rdy = 0;
    logic [15:0] mem [4];
    logic [15:0] exp_buf [4];
    logic [1:0] rl0, rl1;
    logic [15:0] re0, re1, od0, od1;
    logic ov0, ov1, ol0, ol1, bz0, bz1, dn0, dn1;
    int sel = 0, errors = 0, checks = 0;
    logic v, l, b, d;
    logic [15:0] dat;
    logic [1:0] loc;

    typedef struct {
        logic st;
        logic rd;
        logic ev;
        logic [15:0] ed;
        logic el;
        logic eb;
        logic edn;
        logic [1:0] eloc;
    } vec_t;
    vec_t tbl [13];

    assign re0 = mem[rl0];
    assign re1 = mem[rl1];
    assign v = sel == 1 ? ov1 : ov0;
    assign l = sel == 1 ? ol1 : ol0;
    assign b = sel == 1 ? bz1 : bz0;
    assign d = sel == 1 ? dn1 : dn0;
    assign dat = sel == 1 ? od1 : od0;
    assign loc = sel == 1 ? rl1 : rl0;

    always #5 clk = ~clk;

    input_feeder #(.matrixSize(4), .dataSize(16), .skewCycles(0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .busy(bz0), .done(dn0),
        .readLocation(rl0), .readElement(re0), .outValid(ov0), .outReady(rdy),
        .outData(od0), .outLast(ol0)
    );
    input_feeder #(.matrixSize(4), .dataSize(16), .skewCycles(2)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .busy(bz1), .done(dn1),
        .readLocation(rl1), .readElement(re1), .outValid(ov1), .outReady(rdy),
        .outData(od1), .outLast(ol1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic stream_check(input int s, input int skew);
        sel = s;
        rdy = 1;
        start0 = s == 0;
        start1 = s == 1;
        tick;
        start0 = 0;
        start1 = 0;
        for (int k = 0; k < skew + 4; k++) begin
            chk("beat_valid", v, 1);
            chk("beat_data", dat, k < skew ? 16'h0 : exp_buf[(k - skew) & 3]);
            chk("beat_last", l, k == skew + 3);
            chk("beat_busy", b, 1);
            chk("beat_loc", loc, k < skew ? 0 : (k - skew == 3 ? 3 : k - skew + 1));
            tick;
        end
        chk("end_valid", v, 0);
        chk("end_busy", b, 0);
        chk("end_done", d, 1);
        chk("end_loc", loc, 0);
        tick;
        chk("done_drop", d, 0);
    endtask

    initial begin
        int beats, dones;
        mem = '{16'h0011, 16'h0022, 16'h0033, 16'h0044};
        exp_buf = mem;
        tbl[0]  = '{1, 0, 1, 16'h0011, 0, 1, 0, 1};
        tbl[1]  = '{0, 1, 1, 16'h0022, 0, 1, 0, 2};
        tbl[2]  = '{0, 0, 1, 16'h0022, 0, 1, 0, 2};
        tbl[3]  = '{1, 0, 1, 16'h0022, 0, 1, 0, 2};
        tbl[4]  = '{0, 1, 1, 16'h0033, 0, 1, 0, 3};
        tbl[5]  = '{0, 0, 1, 16'h0033, 0, 1, 0, 3};
        tbl[6]  = '{0, 1, 1, 16'h0044, 1, 1, 0, 3};
        tbl[7]  = '{0, 1, 0, 16'h0000, 0, 0, 1, 0};
        tbl[8]  = '{1, 0, 1, 16'h0011, 0, 1, 0, 1};
        tbl[9]  = '{0, 1, 1, 16'h0022, 0, 1, 0, 2};
        tbl[10] = '{0, 1, 1, 16'h0033, 0, 1, 0, 3};
        tbl[11] = '{0, 1, 1, 16'h0044, 1, 1, 0, 3};
        tbl[12] = '{0, 1, 0, 16'h0000, 0, 0, 1, 0};

        #1 rst = 1;
        #2;
        chk("rst_valid0", ov0, 0);
        chk("rst_data0", od0, 0);
        chk("rst_last0", ol0, 0);
        chk("rst_busy0", bz0, 0);
        chk("rst_done0", dn0, 0);
        chk("rst_loc0", rl0, 0);
        chk("rst_valid1", ov1, 0);
        chk("rst_loc1", rl1, 0);
        tick;
        tick;
        rst = 0;
        tick;

        stream_check(0, 0);
        stream_check(1, 2);

        sel = 0;
        for (int i = 0; i < 13; i++) begin
            start0 = tbl[i].st;
            rdy = tbl[i].rd;
            tick;
            chk("tbl_valid", v, tbl[i].ev);
            if (tbl[i].ev) chk("tbl_data", dat, tbl[i].ed);
            chk("tbl_last", l, tbl[i].el);
            chk("tbl_busy", b, tbl[i].eb);
            chk("tbl_done", d, tbl[i].edn);
            chk("tbl_loc", loc, tbl[i].eloc);
        end
        start0 = 0;
        tick;

        sel = 0;
        start0 = 1;
        rdy = 0;
        tick;
        start0 = 0;
        rdy = 1;
        tick;
        chk("wr_held_pre", od0, 16'h0022);
        rdy = 0;
        mem[1] = 16'h0099;
        mem[3] = 16'h0066;
        tick;
        chk("wr_held", od0, 16'h0022);
        rdy = 1;
        tick;
        chk("wr_next", od0, 16'h0033);
        tick;
        chk("wr_idx3", od0, 16'h0066);
        chk("wr_idx3_last", ol0, 1);
        mem[3] = 16'h0077;
        rdy = 0;
        tick;
        chk("wr_idx3_held", od0, 16'h0066);
        rdy = 1;
        tick;
        chk("wr_done", dn0, 1);
        mem = '{16'h0011, 16'h0022, 16'h0033, 16'h0044};
        tick;

        beats = 0;
        dones = 0;
        rdy = 1;
        start0 = 1;
        for (int c = 0; c < 18; c++) begin
            if (c == 10) start0 = 0;
            if (ov0 && rdy) begin
                chk("hold_data", od0, mem[beats[1:0]]);
                beats++;
            end
            tick;
            if (dn0) dones++;
        end
        chk("hold_beats", beats, 8);
        chk("hold_dones", dones, 2);

        start0 = 1;
        tick;
        start0 = 0;
        tick;
        tick;
        chk("pre_rst_data", od0, 16'h0033);
        #2 rst = 1;
        #1;
        chk("arst_valid", ov0, 0);
        chk("arst_data", od0, 0);
        chk("arst_last", ol0, 0);
        chk("arst_busy", bz0, 0);
        chk("arst_done", dn0, 0);
        chk("arst_loc", rl0, 0);
        tick;
        rst = 0;
        for (int c = 0; c < 3; c++) begin
            tick;
            chk("arst_no_done", dn0, 0);
        end
        stream_check(0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/input_feeder.md
INPUT_FEEDER -- requirements
Module: input_feeder

Interface
REQ-001 The block SHALL have parameter matrixSize, default 4, giving the number of elements in the source buffer and the number of real beats streamed.
REQ-002 The block SHALL have parameter dataSize, default 16, giving the element width in bits.
REQ-003 The block SHALL have parameter skewCycles, default 0, giving the number of leading zero-data beats sent before the first real element, for systolic diagonal alignment.
REQ-004 clk  input  1  The single clock; all state updates on its rising edge.
REQ-005 rst  input  1  Reset, asynchronous and active-high.
REQ-006 start  input  1  Request to stream one full vector; sampled only in IDLE.
REQ-007 busy  output  1  High while a stream is in progress, from the start-accepting edge until the last beat is accepted.
REQ-008 done  output  1  Registered one-cycle pulse in the cycle after the last beat is accepted.
REQ-009 readLocation  output  $clog2(matrixSize)  Element index driven to the buffer's combinational read port.
REQ-010 readElement  input  dataSize  Element returned by the buffer for readLocation in the same cycle.
REQ-011 outValid  output  1  Output beat valid.
REQ-012 outReady  input  1  Downstream accepts the beat when outValid and outReady are both high at a rising edge.
REQ-013 outData  output  dataSize  Beat payload, registered.
REQ-014 outLast  output  1  High with the final real element beat only.

Function
REQ-015 The FSM SHALL have states IDLE, SKEW and STREAM.
REQ-016 IDLE with start high SHALL go to SKEW if skewCycles>0, else to STREAM; in the same edge it SHALL load the first beat and set outValid=1 and busy=1.
REQ-017 A beat loaded in SKEW SHALL carry outData=0 and outLast=0; a beat loaded in STREAM SHALL carry outData=readElement sampled at that edge.
REQ-018 readLocation SHALL equal the internal load index, which is 0 in IDLE and SKEW and advances by 1 per real element loaded.
REQ-019 While outValid=1 and outReady=0, outData, outValid and outLast SHALL hold stable; readElement changes SHALL NOT affect the held beat.
REQ-020 On each accepted beat the next beat SHALL be loaded in the same edge, with no bubble: back-to-back acceptance yields one beat per cycle.
REQ-021 SKEW SHALL go to STREAM after skewCycles zero beats have been accepted.
REQ-022 Total beats per stream SHALL be skewCycles+matrixSize; the real element order SHALL be index 0 to matrixSize-1.
REQ-023 outLast SHALL be high exactly on the beat carrying index matrixSize-1.
REQ-024 On acceptance of the outLast beat: outValid->0, busy->0, state->IDLE, load index->0, and done=1 for exactly the next cycle.
REQ-025 start while busy=1 SHALL be ignored with no queuing; start high in the cycle done=1 SHALL begin a new stream.
REQ-026 The load index SHALL NOT wrap within a stream; reaching matrixSize-1 ends the stream as in REQ-024.
REQ-027 If matrixSize is not a power of two, readLocation SHALL never exceed matrixSize-1.

Reset
REQ-028 rst high SHALL immediately force state=IDLE, load index=0, readLocation=0, outValid=0, outLast=0, outData=0, busy=0 and done=0, regardless of clk.
REQ-029 Reset mid-stream SHALL abort the stream with no done pulse; the first start after rst deasserts SHALL begin from beat 0.

Verification
REQ-030 Buffer 0x0011,0x0022,0x0033,0x0044, skewCycles=0, outReady=1, start pulse -> outData 0x0011..0x0044 on 4 consecutive cycles, outLast on 0x0044, done pulse one cycle later.
REQ-031 Same buffer with outReady toggled 1,0,0,1,0,1,1 -> every beat held stable through the stall cycles; delivered sequence identical to REQ-030 with no loss or duplication.
REQ-032 skewCycles=2, outReady=1 -> beats 0x0000,0x0000,0x0011,0x0022,0x0033,0x0044; readLocation stays 0 during the zero beats; outLast only on 0x0044.
REQ-033 start held high for 10 cycles -> exactly one stream until done, then a second stream starts on the done cycle, giving 8 real beats total.
REQ-034 rst asserted asynchronously after beat 2 is accepted -> all outputs go to reset values before the next clk edge; no done pulse; the next start streams from 0x0011.
REQ-035 Buffer writes to index 3 while index 1 is stalled -> the held beat stays 0x0022, and index 3 streams the value present at its load edge.
